// File: rtl/l1d_data_ram_ctrl.sv
// L1D data-line array controller: self-clears every line after reset, then serves
// byte-masked writes and fixed-latency tagged reads (one request per cycle, no backpressure).
module l1d_data_ram_ctrl #(
    parameter int unsigned SETS   = 64,
    parameter int unsigned WAYS   = 4,
    parameter int unsigned LINE_W = 512,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned RD_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    data_ram_vld,
    input  logic                    data_ram_wr,
    input  logic [$clog2(SETS)-1:0] data_ram_set,
    input  logic [$clog2(WAYS)-1:0] data_ram_way,
    input  logic [LINE_W-1:0]       data_ram_wdata,
    input  logic [LINE_W/8-1:0]     data_ram_wmask,
    input  logic [ID_W-1:0]         data_ram_id,
    output logic                    rsp_vld,
    output logic [ID_W-1:0]         rsp_id,
    output logic [LINE_W-1:0]       rsp_rdata,
    output logic                    init_done,
    output logic                    req_drop_err
);

    localparam int unsigned SET_W = $clog2(SETS);
    localparam int unsigned WAY_W = $clog2(WAYS);
    localparam int unsigned IDX_W = SET_W + WAY_W;
    localparam int unsigned LINES = SETS * WAYS;
    localparam int unsigned BYTES = LINE_W / 8;

    typedef enum logic {StInit, StReady} state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   init_cnt_q;
    logic [LINE_W-1:0]  mem [LINES];

    logic               pipe_vld  [RD_LAT];
    logic [ID_W-1:0]    pipe_id   [RD_LAT];
    logic [LINE_W-1:0]  pipe_data [RD_LAT];

    logic [IDX_W-1:0]   req_idx;
    logic               in_init;
    logic               wr_en;
    logic               rd_en;

    // Powers of two make set*WAYS+way a plain concatenation.
    assign req_idx = {data_ram_set, data_ram_way};
    assign in_init = (state_q == StInit);
    assign wr_en   = data_ram_vld & data_ram_wr & ~in_init;
    assign rd_en   = data_ram_vld & ~data_ram_wr & ~in_init;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StInit;
            init_cnt_q   <= '0;
            init_done    <= 1'b0;
            req_drop_err <= 1'b0;
        end else begin
            req_drop_err <= data_ram_vld & in_init;
            unique case (state_q)
                StInit: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (init_cnt_q == '1) begin
                        state_q   <= StReady;
                        init_done <= 1'b1;
                    end
                end
                StReady: begin
                    state_q <= StReady;
                end
            endcase
        end
    end

    // Storage is deliberately not reset; the INIT sweep clears it instead.
    always_ff @(posedge clk) begin
        if (in_init) begin
            mem[init_cnt_q] <= '0;
        end else if (wr_en) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (data_ram_wmask[b]) begin
                    mem[req_idx][8*b +: 8] <= data_ram_wdata[8*b +: 8];
                end
            end
        end
    end

    // Payload stages only advance behind a valid, so the outputs hold the last response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_id[i]   <= '0;
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= rd_en;
            if (rd_en) begin
                pipe_id[0]   <= data_ram_id;
                pipe_data[0] <= mem[req_idx];
            end
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) begin
                    pipe_id[i]   <= pipe_id[i-1];
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
        end
    end

    assign rsp_vld   = pipe_vld[RD_LAT-1];
    assign rsp_id    = pipe_id[RD_LAT-1];
    assign rsp_rdata = pipe_data[RD_LAT-1];

endmodule

// File: tb/tb_l1d_data_ram_ctrl.sv
// Scoreboard bench for l1d_data_ram_ctrl: directed requests push expected responses,
// a negedge monitor pops and checks id, data and arrival cycle.
module tb_l1d_data_ram_ctrl;

    localparam int unsigned SETS   = 64;
    localparam int unsigned WAYS   = 4;
    localparam int unsigned LINE_W = 512;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned SET_W  = $clog2(SETS);
    localparam int unsigned WAY_W  = $clog2(WAYS);
    localparam int          NLINES = SETS * WAYS;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                data_ram_vld;
    logic                data_ram_wr;
    logic [SET_W-1:0]    data_ram_set;
    logic [WAY_W-1:0]    data_ram_way;
    logic [LINE_W-1:0]   data_ram_wdata;
    logic [LINE_W/8-1:0] data_ram_wmask;
    logic [ID_W-1:0]     data_ram_id;
    logic                rsp_vld;
    logic [ID_W-1:0]     rsp_id;
    logic [LINE_W-1:0]   rsp_rdata;
    logic                init_done;
    logic                req_drop_err;

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [LINE_W-1:0] data;
        int                due;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [LINE_W-1:0] P_A5   = {64{8'hA5}};
    localparam logic [LINE_W-1:0] P_A5LO = {{56{8'h00}}, {8{8'hA5}}};
    localparam logic [LINE_W-1:0] P_11   = {64{8'h11}};
    localparam logic [LINE_W-1:0] P_22   = {64{8'h22}};
    localparam logic [LINE_W-1:0] P_33   = {64{8'h33}};
    localparam logic [LINE_W-1:0] P_44   = {64{8'h44}};
    localparam logic [LINE_W-1:0] P_EE   = {64{8'hEE}};
    localparam logic [LINE_W-1:0] P_77   = {64{8'h77}};
    localparam logic [LINE_W-1:0] P_MIX  = {{48{8'h11}}, {8{8'hEE}}, {8{8'h11}}};

    l1d_data_ram_ctrl #(
        .SETS   (SETS),
        .WAYS   (WAYS),
        .LINE_W (LINE_W),
        .ID_W   (ID_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_ram_vld   (data_ram_vld),
        .data_ram_wr    (data_ram_wr),
        .data_ram_set   (data_ram_set),
        .data_ram_way   (data_ram_way),
        .data_ram_wdata (data_ram_wdata),
        .data_ram_wmask (data_ram_wmask),
        .data_ram_id    (data_ram_id),
        .rsp_vld        (rsp_vld),
        .rsp_id         (rsp_id),
        .rsp_rdata      (rsp_rdata),
        .init_done      (init_done),
        .req_drop_err   (req_drop_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d, want finish", cyc);
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (rst_n && rsp_vld) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_rsp got id=%0h cyc=%0d, want none", rsp_id, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (rsp_id !== mon_e.id || rsp_rdata !== mon_e.data || cyc != mon_e.due) begin
                    n_err++;
                    $display("FAIL rsp got id=%0h cyc=%0d data=%h want id=%0h cyc=%0d data=%h",
                             rsp_id, cyc, rsp_rdata, mon_e.id, mon_e.due, mon_e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // All request tasks are entered at a negedge and return at the next negedge.
    task automatic rd(input logic [SET_W-1:0] s, input logic [WAY_W-1:0] w,
                      input logic [ID_W-1:0] id, input logic [LINE_W-1:0] exp_data,
                      input bit expect_rsp);
        exp_t e;
        data_ram_vld = 1'b1;
        data_ram_wr  = 1'b0;
        data_ram_set = s;
        data_ram_way = w;
        data_ram_id  = id;
        if (expect_rsp) begin
            e.id   = id;
            e.data = exp_data;
            e.due  = cyc + RD_LAT;
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic wr(input logic [SET_W-1:0] s, input logic [WAY_W-1:0] w,
                      input logic [LINE_W-1:0] d, input logic [LINE_W/8-1:0] m);
        data_ram_vld   = 1'b1;
        data_ram_wr    = 1'b1;
        data_ram_set   = s;
        data_ram_way   = w;
        data_ram_wdata = d;
        data_ram_wmask = m;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        data_ram_vld = 1'b0;
        data_ram_wr  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int k;
        rst_n          = 1'b0;
        data_ram_vld   = 1'b0;
        data_ram_wr    = 1'b0;
        data_ram_set   = '0;
        data_ram_way   = '0;
        data_ram_wdata = '0;
        data_ram_wmask = '0;
        data_ram_id    = '0;
        repeat (3) @(negedge clk);
        chk("reset_rsp_vld", rsp_vld, '0);
        chk("reset_rsp_id", rsp_id, '0);
        chk("reset_rsp_rdata", rsp_rdata, '0);
        chk("reset_init_done", init_done, '0);
        chk("reset_drop_err", req_drop_err, '0);

        // Release reset; a read issued at cycle 10 of INIT must be dropped.
        rst_n = 1'b1;
        for (int i = 1; i <= NLINES + 1; i++) begin
            @(negedge clk);
            chk($sformatf("init_done_c%0d", i), init_done, (i >= NLINES) ? 1 : 0);
            chk($sformatf("drop_err_c%0d", i), req_drop_err, (i == 11) ? 1 : 0);
            data_ram_vld = (i == 10);
            data_ram_wr  = 1'b0;
            data_ram_id  = 4'd1;
        end
        data_ram_vld = 1'b0;

        rd(6'd5, 2'd2, 4'd3, '0, 1'b1);
        rd(6'd0, 2'd0, 4'd4, '0, 1'b1);
        rd(6'd63, 2'd3, 4'd5, '0, 1'b1);
        idle(RD_LAT + 1);

        wr(6'd5, 2'd2, P_A5, 64'h0000_0000_0000_00FF);
        rd(6'd5, 2'd2, 4'd7, P_A5LO, 1'b1);
        idle(RD_LAT + 1);

        wr(6'd1, 2'd0, P_11, '1);
        wr(6'd1, 2'd1, P_22, '1);
        wr(6'd2, 2'd3, P_33, '1);
        wr(6'd63, 2'd3, P_44, '1);
        wr(6'd1, 2'd0, P_EE, 64'h0000_0000_0000_FF00);
        wr(6'd1, 2'd0, P_77, '0);
        rd(6'd1, 2'd0, 4'd0, P_MIX, 1'b1);
        rd(6'd1, 2'd1, 4'd1, P_22, 1'b1);
        rd(6'd2, 2'd3, 4'd2, P_33, 1'b1);
        rd(6'd63, 2'd3, 4'd3, P_44, 1'b1);
        idle(RD_LAT + 2);
        chk("hold_rsp_vld", rsp_vld, '0);
        chk("hold_rsp_id", rsp_id, 4'd3);
        chk("hold_rsp_rdata", rsp_rdata, P_44);
        chk("ready_drop_err", req_drop_err, '0);

        // Read in flight, then reset: response must be flushed and INIT rerun.
        rd(6'd5, 2'd2, 4'd9, '0, 1'b0);
        data_ram_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_init_done", init_done, '0);
        chk("midrst_rsp_vld", rsp_vld, '0);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        while (!init_done && k < NLINES + 10) begin
            @(negedge clk);
            k++;
        end
        chk("reinit_cycles", k, NLINES);

        rd(6'd5, 2'd2, 4'd10, '0, 1'b1);
        rd(6'd1, 2'd0, 4'd11, '0, 1'b1);
        idle(RD_LAT + 2);
        chk("rsp_queue_empty", exp_q.size(), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
